// File: rtl/instr_sequencer_if.sv
// Interface bundling the instruction sequencer's program-load, control,
// processor-handshake and status signals.
// Named const_val rather than const because const is a reserved word.
interface instr_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [33:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          done;
  logic [2:0]    instr;
  logic [4:0]    reg1;
  logic [4:0]    reg2;
  logic [4:0]    reg3;
  logic [15:0]   const_val;
  logic          busy;
  logic          seq_done;
  logic          aborted;
  logic [AW:0]   issued_count;

  // Driver side: loads the program, controls runs and models the processor.
  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, abort, done,
    input  instr, reg1, reg2, reg3, const_val, busy, seq_done, aborted, issued_count
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, abort, done,
    output instr, reg1, reg2, reg3, const_val, busy, seq_done, aborted, issued_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program buffer and presents one
// instruction per processor done handshake, parking on a filler
// instruction (read r0, no write) when idle or after a run ends.
module instr_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic           clk,
  input logic           rst,
  instr_sequencer_if.slave bus
);

  localparam logic [33:0] Filler   = {3'b001, 31'b0};
  localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWaitSlot,
    StRun
  } state_e;

  logic [33:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] issued_q, issued_d;
  logic [33:0] fields_q, fields_d;
  logic        abort_pend_q, abort_pend_d;
  logic        busy_q, busy_d;
  logic        seq_done_q, seq_done_d;
  logic        aborted_q, aborted_d;
  logic        abort_now;

  // Program buffer: writable only while idle, contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q == StIdle)) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Abort seen now or earlier in this run; acted on at the next issue edge.
  assign abort_now = abort_pend_q | bus.abort;

  // Next-state, issue and run-termination logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    len_d        = len_q;
    issued_d     = issued_q;
    fields_d     = fields_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    seq_done_d   = 1'b0;
    aborted_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        fields_d = Filler;
        if (bus.start && (bus.prog_len != '0)) begin
          len_d        = (bus.prog_len > DepthLen) ? DepthLen : bus.prog_len;
          pc_d         = '0;
          issued_d     = '0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = StWaitSlot;
        end
      end

      StWaitSlot: begin
        if (bus.abort) begin
          // Nothing issued yet: end the run straight away.
          fields_d   = Filler;
          busy_d     = 1'b0;
          seq_done_d = 1'b1;
          aborted_d  = 1'b1;
          state_d    = StIdle;
        end else if (bus.done) begin
          fields_d = mem[0];
          pc_d     = (AW + 1)'(1);
          issued_d = (AW + 1)'(1);
          state_d  = StRun;
        end
      end

      StRun: begin
        if (bus.done) begin
          if (abort_now) begin
            fields_d     = Filler;
            busy_d       = 1'b0;
            seq_done_d   = 1'b1;
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = StIdle;
          end else if (pc_q < len_q) begin
            fields_d = mem[pc_q[AW-1:0]];
            pc_d     = pc_q + 1'b1;
            issued_d = issued_q + 1'b1;
          end else begin
            // Last instruction has completed.
            fields_d   = Filler;
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
            state_d    = StIdle;
          end
        end else if (bus.abort) begin
          abort_pend_d = 1'b1;
        end
      end

      default: begin
        fields_d = Filler;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  // State and output registers; reset parks the processor on the filler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      fields_q     <= Filler;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      seq_done_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      fields_q     <= fields_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      seq_done_q   <= seq_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign bus.instr        = fields_q[33:31];
  assign bus.reg1         = fields_q[30:26];
  assign bus.reg2         = fields_q[25:21];
  assign bus.reg3         = fields_q[20:16];
  assign bus.const_val    = fields_q[15:0];
  assign bus.busy         = busy_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.aborted      = aborted_q;
  assign bus.issued_count = issued_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: program load, full buffer,
// abort paths, ignored commands, reset mid-run and a small processor model.
module tb_instr_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [33:0] FILL  = {3'b001, 31'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_sequencer_if #(.AW(AW)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;
  logic mon_en = 1'b0;
  logic [33:0] img [DEPTH];
  logic [15:0] regs [32];

  function automatic logic [33:0] fields();
    return {bus.instr, bus.reg1, bus.reg2, bus.reg3, bus.const_val};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [33:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(addr);
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic go(input int len);
    bus.prog_len = (AW + 1)'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Processor busy for 3 cycles, then one issue edge.
  task automatic slot();
    bus.done = 1'b0;
    repeat (3) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  // Fields must not change across an edge where done was sampled low.
  always @(posedge clk) begin
    logic [33:0] pre;
    logic        d_s;
    pre = fields();
    d_s = bus.done;
    #2;
    if (mon_en && !d_s && !rst && (fields() != pre)) viol++;
  end

  initial begin
    logic [33:0] cur;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.done = 1'b0;
    repeat (2) tick();
    check("rst_fields", fields(), FILL);
    check("rst_busy", bus.busy, 0);
    check("rst_seq_done", bus.seq_done, 0);
    check("rst_aborted", bus.aborted, 0);
    check("rst_issued", bus.issued_count, 0);
    rst = 1'b0;
    tick();

    // Two-instruction program.
    img[0] = {3'b000, 5'd0, 5'd0, 5'd5, 16'h0012};
    img[1] = {3'b001, 5'd5, 5'd0, 5'd0, 16'h0000};
    load(0, img[0]);
    load(1, img[1]);
    go(2);
    check("t1_busy", bus.busy, 1);
    check("t1_wait_fill", fields(), FILL);
    slot();
    check("t1_i0", fields(), img[0]);
    check("t1_cnt0", bus.issued_count, 1);
    slot();
    check("t1_i1", fields(), img[1]);
    slot();
    check("t1_end_fill", fields(), FILL);
    check("t1_seq_done", bus.seq_done, 1);
    check("t1_aborted", bus.aborted, 0);
    check("t1_busy_end", bus.busy, 0);
    check("t1_cnt", bus.issued_count, 2);
    tick();
    check("t1_seq_pulse", bus.seq_done, 0);

    // Full buffer with prog_len beyond DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = {3'(i), 5'(i), 5'(i + 1), 5'(i + 2), 16'(i * 16'h0111 + 16'h00a0)};
      load(i, img[i]);
    end
    go(20);
    for (int i = 0; i < DEPTH; i++) begin
      slot();
      check($sformatf("t2_i%0d", i), fields(), img[i]);
      check($sformatf("t2_cnt%0d", i), bus.issued_count, 64'(i + 1));
    end
    slot();
    check("t2_end_fill", fields(), FILL);
    check("t2_seq_done", bus.seq_done, 1);
    check("t2_cnt", bus.issued_count, 16);

    // Abort one cycle after mem[1] issues in a 5-long run.
    go(5);
    slot();
    slot();
    check("t3_i1", fields(), img[1]);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t3_hold", fields(), img[1]);
    check("t3_busy_pend", bus.busy, 1);
    slot();
    check("t3_fill", fields(), FILL);
    check("t3_seq_done", bus.seq_done, 1);
    check("t3_aborted", bus.aborted, 1);
    check("t3_busy", bus.busy, 0);
    check("t3_cnt", bus.issued_count, 2);
    tick();
    check("t3_seq_pulse", bus.seq_done, 0);
    check("t3_ab_pulse", bus.aborted, 0);

    // Abort while waiting for the first slot.
    go(3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t3w_seq_done", bus.seq_done, 1);
    check("t3w_aborted", bus.aborted, 1);
    check("t3w_fill", fields(), FILL);
    check("t3w_cnt", bus.issued_count, 0);

    // Write and start while busy are ignored.
    go(2);
    load(3, 34'h3_ffff_ffff);
    go(5);
    slot();
    slot();
    slot();
    check("t4_len_kept", bus.seq_done, 1);
    check("t4_cnt", bus.issued_count, 2);
    go(4);
    repeat (4) slot();
    check("t4_mem3", fields(), img[3]);
    slot();
    go(0);
    check("t4_len0_busy", bus.busy, 0);
    tick();
    check("t4_len0_done", bus.seq_done, 0);

    // Write and start together; start coinciding with an issue edge.
    img[0] = {3'b101, 5'd9, 5'd8, 5'd7, 16'hbeef};
    bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = img[0];
    bus.prog_len = 1; bus.start = 1'b1; bus.done = 1'b1;
    tick();
    bus.prog_we = 1'b0; bus.start = 1'b0;
    check("t5_no_issue", fields(), FILL);
    tick();
    bus.done = 1'b0;
    check("t5_new_word", fields(), img[0]);
    slot();
    check("t5_end", bus.seq_done, 1);

    // Reset in the middle of a run.
    go(4);
    slot();
    slot();
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_fill", fields(), FILL);
    check("t6_busy", bus.busy, 0);
    check("t6_cnt", bus.issued_count, 0);
    tick();
    rst = 1'b0;
    go(2);
    slot();
    check("t6_restart", fields(), img[0]);
    slot();
    slot();

    // Integration with a small processor model: 000 load, 001 read, 010 add.
    img[0] = {3'b000, 5'd0, 5'd0, 5'd5, 16'h0012};
    img[1] = {3'b000, 5'd0, 5'd0, 5'd6, 16'h0003};
    img[2] = {3'b010, 5'd5, 5'd6, 5'd7, 16'h0000};
    for (int i = 0; i < 3; i++) load(i, img[i]);
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mon_en = 1'b1;
    go(3);
    cur = FILL;
    for (int k = 0; k < 4; k++) begin
      slot();
      case (cur[33:31])
        3'b000: regs[cur[20:16]] = cur[15:0];
        3'b010: regs[cur[20:16]] = regs[cur[30:26]] + regs[cur[25:21]];
        default: ;
      endcase
      cur = fields();
    end
    mon_en = 1'b0;
    check("t7_r7", regs[7], 16'h0015);
    check("t7_seq_done", bus.seq_done, 1);
    check("t7_stable", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the register-file instruction processor.
- Holds a small writable program buffer. Each time the processor signals it is free (done high), the block presents the next instruction's fields (instr, reg1, reg2, reg3, const).
- Runs a loaded program of N instructions to completion or abort, then parks on a harmless filler instruction.

Parameters:
DEPTH, 16, number of program buffer entries
AW, 4, program address width (log2 DEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
prog_we  input  1  program buffer write enable
prog_addr  input  AW  program buffer write address
prog_data  input  34  instruction word: [33:31] instr, [30:26] reg1, [25:21] reg2, [20:16] reg3, [15:0] const
prog_len  input  AW+1  number of instructions to run; sampled on start
start  input  1  begin program run (pulse)
abort  input  1  stop issuing after the in-flight instruction (pulse)
done  input  1  processor done flag
instr  output  3  instruction opcode to processor (registered)
reg1  output  5  read address 1 (registered)
reg2  output  5  read address 2 (registered)
reg3  output  5  write address (registered)
const  output  16  constant (registered)
busy  output  1  high while a program is pending or running
seq_done  output  1  one-cycle pulse when a run ends, normally or by abort
aborted  output  1  one-cycle pulse, coincident with seq_done, only on an abort-terminated run
issued_count  output  AW+1  instructions issued in the current or last run

Behaviour:
- Filler instruction: instr=3'b001, reg1=reg2=reg3=0, const=0 (read r0; no register write).
- Reset (async) values:
  - outputs = filler; busy=0; seq_done=0; aborted=0; issued_count=0.
  - state IDLE; pc=0.
  - Program buffer contents are not reset.
- Issue edge: any rising clk edge at which done==1 is sampled.
  - The processor starts executing whatever fields are stable after that edge.
  - The fields presented before that edge belong to the instruction that just completed.
  - Field outputs change only on issue edges, on abort from WAIT_SLOT, or on reset; they are stable while done==0.
- Program writes:
  - In IDLE, prog_we writes prog_data to mem[prog_addr] at the clock edge.
  - Writes while busy are ignored.
- States:
  - IDLE
    - start with prog_len!=0: latch len=min(prog_len,DEPTH); pc=0; issued_count=0; busy=1; go WAIT_SLOT.
    - start with prog_len==0 is ignored.
    - Issue edges keep the filler.
  - WAIT_SLOT
    - On an issue edge: outputs=mem[0]; pc=1; issued_count=1; go RUN.
    - abort (takes priority): outputs stay filler; busy=0; seq_done=1; aborted=1; go IDLE.
  - RUN
    - On an issue edge with pc<len: outputs=mem[pc]; pc++; issued_count++.
    - On an issue edge with pc==len (last instruction completed): outputs=filler; busy=0; seq_done=1; go IDLE.
    - abort: set abort_pend. At the next issue edge (including the same edge), outputs=filler; busy=0; seq_done=1; aborted=1; go IDLE. No further program entries are issued.
- start while busy is ignored; abort in IDLE is ignored.
- Simultaneous events:
  - prog_we and start in the same IDLE cycle: the write is performed and start is accepted. The written word is visible to the run, since the buffer is read at issue edges.
  - start and an issue edge in the same IDLE cycle: go WAIT_SLOT only; mem[0] issues at the next issue edge. First-issue latency is 1 cycle after done is next seen high.
- seq_done and aborted are high for exactly one cycle.
- pc width is AW+1 so that len=DEPTH is representable; no wrap-around within a run.
- Reset mid-run: outputs return to filler immediately (async). An in-flight processor instruction completes unaffected; the sequencer does not track it.

Test Plan:
- Load mem[0]={000,r0,r0,r5,0x0012}, mem[1]={001,r5,…}, prog_len=2, start; done model holds done=0 for 3 cycles per instruction -> mem[0] fields appear on the first issue edge, mem[1] on the second, filler on the third; seq_done pulses once; issued_count=2; busy falls with seq_done.
- Full buffer: DEPTH=16 entries, prog_len=20 -> exactly 16 issued in address order; issued_count=16; no wrap to entry 0.
- abort asserted 1 cycle after mem[1] issued in a 5-long run -> no mem[2]; filler at the next issue edge; seq_done=aborted=1 for one cycle; issued_count=2.
- prog_we to addr 3 while busy, then rerun -> mem[3] unchanged. start with prog_len=0 -> busy stays 0, no seq_done. start while busy -> ignored.
- Assert rst while RUN with done=0 -> outputs = filler within the same cycle, busy=0, issued_count=0. After release, start runs from mem[0].
- Integrate with the real processor: program load r5=0x0012, load r6=0x0003, add r7=r5+r6 -> processor writes r7=0x0015; field outputs never change while done=0.
